// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pkg
// Description : Shared immediate-format select codes and the S1 payload type
//               used by the immediate encoder (and matching the codes used by
//               the immediate generator).
// Revision    : 1.0 - initial release
// ============================================================================
package imm_encoder_pkg;

  localparam int unsigned c_imm_sel_w = 5;

  // Format codes; 6..31 are illegal.
  typedef enum logic [c_imm_sel_w-1:0] {
    IMM_S      = 5'd0,
    IMM_B      = 5'd1,
    IMM_U      = 5'd2,
    IMM_J      = 5'd3,
    IMM_I      = 5'd4,
    IMM_I_STAR = 5'd5
  } imm_sel_e;

  // Request captured in stage 1.
  typedef struct packed {
    logic [31:0]            base;
    logic [31:0]            imm;
    logic [c_imm_sel_w-1:0] sel;
  } s1_payload_t;

endpackage
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_if
// Description : Request/result handshake bundle of the immediate encoder.
//   master : instruction builder side (drives requests, accepts results)
//   slave  : encoder side
//   in_valid/in_ready/in_base/in_imm/in_imm_sel : request channel
//   out_valid/out_ready/out_inst/out_err        : result channel
//   err_cnt                                     : saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [4:0]  in_imm_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_cnt;

  modport master (
    output in_valid, in_base, in_imm, in_imm_sel, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_base, in_imm, in_imm_sel, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imm_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_pack
// Description : Combinational packer: scatters an immediate into the bit
//               positions of the selected RISC-V format; all other bits come
//               from the base word. Illegal selects return the base word.
//   base : base instruction word
//   imm  : full-width immediate
//   sel  : format code
//   inst : packed instruction
// Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0]            base,
  input  logic [31:0]            imm,
  input  logic [c_imm_sel_w-1:0] sel,
  output logic [31:0]            inst
);

  always_comb begin
    inst = base;
    case (sel)
      IMM_S:      inst = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      IMM_B:      inst = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      IMM_U:      inst = {imm[31:12], base[11:0]};
      IMM_J:      inst = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      IMM_I:      inst = {imm[11:0], base[19:0]};
      // Shift-immediate: funct7 in [31:25] stays from the base word.
      IMM_I_STAR: inst = {base[31:25], imm[4:0], base[19:0]};
      default:    inst = base;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Two-stage valid/ready immediate encoder (inverse of the
//               immediate generator). Stage 1 captures the request and
//               evaluates the range check; stage 2 holds the packed word.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_encoder_if.slave (request, result, err_cnt)
// Configuration : IMM_ENC_RANGE_CHECK_EN enables the range check, illegal-
//                 select detection and the saturating error counter; when
//                 undefined out_err and err_cnt are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  imm_encoder_if.slave  bus
);

  logic        r_s1_valid;
  s1_payload_t r_s1;
  logic        r_s2_valid;
  logic [31:0] r_s2_inst;
  logic        w_s2_load;
  logic        w_s1_adv;
  logic        w_in_ready;
  logic [31:0] w_packed;

  // S2 takes new data whenever it is empty or its content is leaving now;
  // this lets a full pipeline accept and emit in the same cycle.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign w_in_ready = !r_s1_valid || w_s1_adv;

  imm_pack u_imm_pack (
    .base (r_s1.base),
    .imm  (r_s1.imm),
    .sel  (r_s1.sel),
    .inst (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1.base <= bus.in_base;
        r_s1.imm  <= bus.in_imm;
        r_s1.sel  <= bus.in_imm_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inst <= w_packed;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_inst  = r_s2_inst;

`ifdef IMM_ENC_RANGE_CHECK_EN
  logic        w_s1_err;
  logic        r_s2_err;
  logic [15:0] r_err_cnt;

  // Sign-extension checks: the dropped upper bits must all equal the top
  // representable bit; B/J also require an even offset.
  always_comb begin
    w_s1_err = 1'b1;
    case (r_s1.sel)
      IMM_I, IMM_S: w_s1_err = !((&r_s1.imm[31:11]) || !(|r_s1.imm[31:11]));
      IMM_B:        w_s1_err = !((&r_s1.imm[31:12]) || !(|r_s1.imm[31:12])) || r_s1.imm[0];
      IMM_J:        w_s1_err = !((&r_s1.imm[31:20]) || !(|r_s1.imm[31:20])) || r_s1.imm[0];
      IMM_U:        w_s1_err = |r_s1.imm[11:0];
      IMM_I_STAR:   w_s1_err = |r_s1.imm[31:5];
      default:      w_s1_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_err <= 1'b0;
    end else if (w_s2_load && r_s1_valid) begin
      r_s2_err <= w_s1_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_s2_valid && bus.out_ready && r_s2_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.out_err = r_s2_err;
  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.out_err = 1'b0;
  assign bus.err_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
